// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - byte-serial instruction fetch stage; optional fetch timeout under `ifdef IFETCH_TIMEOUT_EN
module instr_fetch #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] PC,
   output logic        MEM_REQ,
   output logic [31:0] MEM_ADDR,
   input  logic [7:0]  MEM_DATA,
   input  logic        MEM_VALID,
   output logic [31:0] INSTRUCTION,
   output logic        INSTR_VALID,
   output logic        STALL,
   output logic        FAULT
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fpc_q, fpc_d;
   logic [1:0]  idx_q, idx_d;
   logic [23:0] asm_q, asm_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic        stall_q, stall_d;
   logic        handshake;

`ifdef IFETCH_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] cnt_q, cnt_d;
   logic       fault_q, fault_d;
`endif

   assign handshake = req_q & MEM_VALID;

   always_comb begin
      state_d = state_q;
      fpc_d   = fpc_q;
      idx_d   = idx_q;
      asm_d   = asm_q;
      instr_d = instr_q;
      valid_d = valid_q;
      req_d   = req_q;
      addr_d  = addr_q;
      stall_d = stall_q;
`ifdef IFETCH_TIMEOUT_EN
      cnt_d   = cnt_q;
      fault_d = fault_q;
`endif
      case (state_q)
         S_IDLE: begin
            fpc_d   = PC;
            idx_d   = 2'd0;
            addr_d  = PC;
            req_d   = 1'b1;
            stall_d = 1'b1;
            valid_d = 1'b0;
            state_d = S_FETCH;
`ifdef IFETCH_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
         end
         S_FETCH: begin
            if (handshake) begin
`ifdef IFETCH_TIMEOUT_EN
               cnt_d = 8'd0;
`endif
               if (idx_q != 2'd3) begin
                  case (idx_q)
                     2'd0:    asm_d[23:16] = MEM_DATA;
                     2'd1:    asm_d[15:8]  = MEM_DATA;
                     default: asm_d[7:0]   = MEM_DATA;
                  endcase
                  idx_d  = idx_q + 2'd1;
                  addr_d = fpc_q + {30'd0, idx_q} + 32'd1;
               end else begin
                  instr_d = {asm_q, MEM_DATA};
                  valid_d = 1'b1;
                  stall_d = 1'b0;
                  req_d   = 1'b0;
                  state_d = S_HOLD;
               end
            end
`ifdef IFETCH_TIMEOUT_EN
            // a handshake on the same edge takes priority over the timeout
            else if (cnt_q == TO_LAST) begin
               instr_d = NOP_INSTR;
               valid_d = 1'b1;
               fault_d = 1'b1;
               stall_d = 1'b0;
               req_d   = 1'b0;
               cnt_d   = 8'd0;
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         S_HOLD: begin
            if (PC != fpc_q) begin
               fpc_d   = PC;
               idx_d   = 2'd0;
               addr_d  = PC;
               req_d   = 1'b1;
               stall_d = 1'b1;
               valid_d = 1'b0;
               state_d = S_FETCH;
`ifdef IFETCH_TIMEOUT_EN
               cnt_d   = 8'd0;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         fpc_q   <= 32'd0;
         idx_q   <= 2'd0;
         asm_q   <= 24'd0;
         instr_q <= 32'd0;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
         addr_q  <= 32'd0;
         stall_q <= 1'b1;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         idx_q   <= idx_d;
         asm_q   <= asm_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         stall_q <= stall_d;
      end
   end

`ifdef IFETCH_TIMEOUT_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt_q   <= 8'd0;
         fault_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end
   assign FAULT = fault_q;
`else
   assign FAULT = 1'b0;
`endif

   assign MEM_REQ     = req_q;
   assign MEM_ADDR    = addr_q;
   assign INSTRUCTION = instr_q;
   assign INSTR_VALID = valid_q;
   assign STALL       = stall_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a byte-array memory model
module tb_instr_fetch;

   localparam logic [31:0] NOP = 32'h1300_0013;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] PC;
   logic        MEM_REQ;
   logic [31:0] MEM_ADDR;
   logic [7:0]  MEM_DATA;
   logic        MEM_VALID;
   logic [31:0] INSTRUCTION;
   logic        INSTR_VALID;
   logic        STALL;
   logic        FAULT;

   logic [7:0]  mem [0:255];
   int          total = 0;
   int          bad = 0;
   logic        fault_exp = 1'b0;

   instr_fetch #(.NOP_INSTR(NOP), .TIMEOUT(4)) dut (
      .CLK(CLK), .RESET(RESET), .PC(PC),
      .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_VALID(MEM_VALID),
      .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID), .STALL(STALL), .FAULT(FAULT)
   );

   always #5 CLK = ~CLK;

   assign MEM_DATA = mem[MEM_ADDR[7:0]];

   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [31:0] w;
      logic [31:0] t;
      w = 32'd0;
      for (int k = 0; k < 4; k++) begin
         t = a + 32'(k);
         w = {w[23:0], mem[t[7:0]]};
      end
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_bytes(input logic [31:0] base, input int k0, input int waits,
                           output int stall_cyc, output int ncyc);
      int w;
      stall_cyc = 0;
      ncyc = 0;
      for (int k = k0; k < 4; k++) begin
         w = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
         for (int i = 0; i < w; i++) begin
            MEM_VALID = 1'b0;
            @(negedge CLK);
            ncyc++;
            if (STALL) stall_cyc++;
            chk("wait_addr", MEM_ADDR, base + 32'(k));
            chk("wait_req", {31'd0, MEM_REQ}, 32'd1);
         end
         MEM_VALID = 1'b1;
         @(negedge CLK);
         ncyc++;
         if (STALL) stall_cyc++;
         if (k < 3) chk("next_addr", MEM_ADDR, base + 32'(k) + 32'd1);
      end
      MEM_VALID = 1'b0;
      chk("word", INSTRUCTION, word_at(base));
      chk("valid", {31'd0, INSTR_VALID}, 32'd1);
      chk("stall_done", {31'd0, STALL}, 32'd0);
      chk("req_done", {31'd0, MEM_REQ}, 32'd0);
      chk("fault", {31'd0, FAULT}, {31'd0, fault_exp});
   endtask

   task automatic fetch_check(input logic [31:0] pc, input int waits,
                              output int stall_total, output int edges);
      int sc, nc;
      PC = pc;
      MEM_VALID = 1'b0;
      @(negedge CLK);
      chk("entry_req", {31'd0, MEM_REQ}, 32'd1);
      chk("entry_addr", MEM_ADDR, pc);
      chk("entry_stall", {31'd0, STALL}, 32'd1);
      chk("entry_valid", {31'd0, INSTR_VALID}, 32'd0);
      do_bytes(pc, 0, waits, sc, nc);
      stall_total = sc + 1;
      edges = nc + 1;
   endtask

   initial begin
      int st, ed, sc, nc;
      logic [31:0] cur, npc;

      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h00; mem[3] = 8'h03;
      mem[4] = 8'h02; mem[5] = 8'h05; mem[6] = 8'h06; mem[7] = 8'h07;

      RESET = 1'b1;
      PC = 32'd0;
      MEM_VALID = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_instr", INSTRUCTION, 32'd0);
      chk("rst_valid", {31'd0, INSTR_VALID}, 32'd0);
      chk("rst_req", {31'd0, MEM_REQ}, 32'd0);
      chk("rst_addr", MEM_ADDR, 32'd0);
      chk("rst_stall", {31'd0, STALL}, 32'd1);
      chk("rst_fault", {31'd0, FAULT}, 32'd0);

      // first fetch out of IDLE, memory always ready
      RESET = 1'b0;
      fetch_check(32'd0, 0, st, ed);
      chk("t1_word", INSTRUCTION, 32'h0102_0003);
      chk("t1_latency", 32'(ed), 32'd5);

      // MEM_VALID with no request must be ignored in HOLD
      MEM_VALID = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         chk("hold_valid", {31'd0, INSTR_VALID}, 32'd1);
         chk("hold_req", {31'd0, MEM_REQ}, 32'd0);
         chk("hold_instr", INSTRUCTION, 32'h0102_0003);
      end
      MEM_VALID = 1'b0;

      fetch_check(32'd4, 0, st, ed);
      chk("t2_word", INSTRUCTION, 32'h0205_0607);

      fetch_check(32'h10, 3, st, ed);
      chk("t3_stall_cycles", 32'(st), 32'd16);

      // PC changes after the first byte: old fetch completes, new one follows
      PC = 32'h20;
      @(negedge CLK);
      chk("mid_entry_addr", MEM_ADDR, 32'h20);
      MEM_VALID = 1'b1;
      @(negedge CLK);
      PC = 32'h8;
      do_bytes(32'h20, 1, 0, sc, nc);
      @(negedge CLK);
      chk("mid_valid_drop", {31'd0, INSTR_VALID}, 32'd0);
      chk("mid_new_addr", MEM_ADDR, 32'h8);
      chk("mid_new_req", {31'd0, MEM_REQ}, 32'd1);
      chk("mid_new_stall", {31'd0, STALL}, 32'd1);
      do_bytes(32'h8, 0, -1, sc, nc);

      // reset with two bytes captured
      PC = 32'h30;
      @(negedge CLK);
      MEM_VALID = 1'b1;
      repeat (2) @(negedge CLK);
      chk("pre_rst_addr", MEM_ADDR, 32'h32);
      RESET = 1'b1;
      @(negedge CLK);
      chk("mrst_instr", INSTRUCTION, 32'd0);
      chk("mrst_valid", {31'd0, INSTR_VALID}, 32'd0);
      chk("mrst_req", {31'd0, MEM_REQ}, 32'd0);
      chk("mrst_addr", MEM_ADDR, 32'd0);
      chk("mrst_stall", {31'd0, STALL}, 32'd1);
      @(negedge CLK);
      chk("mrst_req2", {31'd0, MEM_REQ}, 32'd0);
      RESET = 1'b0;
      fetch_check(32'h40, -1, st, ed);

      fetch_check(32'hFFFF_FFFE, -1, st, ed);
      cur = 32'hFFFF_FFFE;

      for (int n = 0; n < 20; n++) begin
         npc = $urandom;
         if (npc == cur) npc = npc + 32'd4;
         fetch_check(npc, -1, st, ed);
         cur = npc;
      end

`ifdef IFETCH_TIMEOUT_EN
      PC = 32'h50;
      MEM_VALID = 1'b0;
      @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("to_pending_valid", {31'd0, INSTR_VALID}, 32'd0);
         chk("to_pending_req", {31'd0, MEM_REQ}, 32'd1);
      end
      @(negedge CLK);
      chk("to_instr", INSTRUCTION, NOP);
      chk("to_valid", {31'd0, INSTR_VALID}, 32'd1);
      chk("to_fault", {31'd0, FAULT}, 32'd1);
      chk("to_req", {31'd0, MEM_REQ}, 32'd0);
      fault_exp = 1'b1;
      fetch_check(32'h60, -1, st, ed);
      fetch_check(32'h64, 0, st, ed);
      RESET = 1'b1;
      @(negedge CLK);
      chk("to_fault_clr", {31'd0, FAULT}, 32'd0);
      fault_exp = 1'b0;
      RESET = 1'b0;
      fetch_check(32'h70, -1, st, ed);
`else
      PC = 32'h50;
      MEM_VALID = 1'b0;
      @(negedge CLK);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         chk("nto_req", {31'd0, MEM_REQ}, 32'd1);
         chk("nto_valid", {31'd0, INSTR_VALID}, 32'd0);
         chk("nto_fault", {31'd0, FAULT}, 32'd0);
      end
      do_bytes(32'h50, 0, 0, sc, nc);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
